string_match_engine: RTL and testbench
======================================

// Module: string_match_engine
// PURPOSE
//  Parametrised brute-force substring search engine: counts occurrences of a pattern (pattern ROM)
//  in a text (text ROM), starting at a programmable text offset. Successor to the fixed 8-bit /
//  4-char / 55-char matcher: adds runtime pattern/text lengths, overlap mode, saturating count,
//  start/busy/done handshake, per-match pulse and last-match address. Sits between the top-level
//  switches/start button and the two synchronous ROMs; count drives the display path.
// PARAMETERS
//  DATA_W   8  character width (bits)
//  TADDR_W  8  text ROM address width; max text length 2**TADDR_W
//  PADDR_W  3  pattern ROM address width; max pattern length 2**PADDR_W
//  CNT_W    8  match counter width
// PORTS
//  clk        in   1          system clock, all logic on rising edge
//  rst        in   1          synchronous reset, active-high
//  start      in   1          request search; sampled only in IDLE
//  start_addr in   TADDR_W    first text index of search window, latched at accepted start
//  text_len   in   TADDR_W+1  text length in chars, latched at accepted start
//  pat_len    in   PADDR_W+1  pattern length in chars, latched at accepted start
//  overlap    in   1          1: after a match advance 1; 0: advance pat_len; latched at start
//  txt_addr   out  TADDR_W    text ROM address (ROM read latency 1 cycle)
//  txt_data   in   DATA_W     text ROM data
//  pat_addr   out  PADDR_W    pattern ROM address (ROM read latency 1 cycle)
//  pat_data   in   DATA_W     pattern ROM data
//  busy       out  1          high from cycle after accepted start until DONE inclusive
//  done       out  1          one-cycle pulse in DONE state
//  match      out  1          one-cycle pulse when a full pattern match is confirmed
//  count      out  CNT_W      matches found; saturates at 2**CNT_W-1
//  count_sat  out  1          sticky: a match occurred while count was saturated
//  last_addr  out  TADDR_W    window base index of most recent match
// BEHAVIOUR
//  Reset: state=IDLE; busy, done, match, count, count_sat, last_addr, txt_addr, pat_addr all 0.
//  Reset mid-search aborts immediately, no done pulse. Reset wins over every other event.
//  Regs: base b (TADDR_W+1 bits), offset j (PADDR_W+1 bits); txt_addr=b+j (low TADDR_W), pat_addr=j.
//  FSM:
//   IDLE: start=1 -> latch inputs, b<=start_addr, j<=0, count<=0, count_sat<=0, last_addr<=0 -> CHECK.
//   CHECK: if pat_len==0 or b+pat_len>text_len (TADDR_W+2-bit compare, no wrap) -> DONE; else FETCH.
//   FETCH: ROMs register txt_addr/pat_addr (1 cycle) -> COMPARE.
//   COMPARE: txt_data!=pat_data -> b<=b+1, j<=0 -> CHECK.
//            equal and j<pat_len-1 -> j<=j+1 -> FETCH.
//            equal and j==pat_len-1 -> match=1 (this cycle), last_addr<=b, count<=count+1
//            unless all-ones (then count holds, count_sat<=1), j<=0, b<=b+(overlap?1:pat_len) -> CHECK.
//   DONE: done=1, busy=1 for this single cycle -> IDLE.
//  Per char compare = 2 cycles (FETCH+COMPARE); per window step +1 (CHECK).
//  start while not IDLE is ignored; input changes after acceptance have no effect.
//  count, count_sat, last_addr hold after DONE until next accepted start.
//  pat_len>2**PADDR_W or text_len>2**TADDR_W: out of range, behaviour not required.
// TESTING
//  1 text "ABABAB" (len 6), pat "ABA", start_addr 0, overlap=1 -> count=2, last_addr=2, 2 match pulses, 1 done.
//  2 same, overlap=0 -> count=1, last_addr=0; start_addr=1, overlap=1 -> count=1, last_addr=2.
//  3 pat_len=0, start at cycle 0 -> CHECK cyc1, done=1 cyc2, count=0; text_len=3, pat_len=4 -> same timing.
//  4 CNT_W=2, text "AAAAAA", pat "A" -> count=3, count_sat=1, last_addr=5, 6 match pulses.
//  5 start pulsed every cycle during search -> exactly one done, result equals single-start run.
//  6 rst asserted mid-COMPARE -> next cycle all outputs 0, state IDLE; new start runs test 1 correctly.

Source files
------------

// File: rtl/string_match_engine.sv
// Brute-force substring counter: slides a pat_len window across a text ROM from a start offset,
// comparing one character per FETCH/COMPARE pair and counting full-pattern matches.
module string_match_engine #(
  parameter int DATA_W  = 8,
  parameter int TADDR_W = 8,
  parameter int PADDR_W = 3,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [TADDR_W-1:0] start_addr,
  input  logic [TADDR_W:0]   text_len,
  input  logic [PADDR_W:0]   pat_len,
  input  logic               overlap,
  output logic [TADDR_W-1:0] txt_addr,
  input  logic [DATA_W-1:0]  txt_data,
  output logic [PADDR_W-1:0] pat_addr,
  input  logic [DATA_W-1:0]  pat_data,
  output logic               busy,
  output logic               done,
  output logic               match,
  output logic [CNT_W-1:0]   count,
  output logic               count_sat,
  output logic [TADDR_W-1:0] last_addr
);

  typedef enum logic [2:0] {IDLE, CHECK, FETCH, COMPARE, DONE} state_t;

  localparam logic [TADDR_W:0] B_ONE = 1;
  localparam logic [PADDR_W:0] J_ONE = 1;

  state_t             state, state_nxt;
  logic [TADDR_W:0]   b;
  logic [PADDR_W:0]   j;
  logic [TADDR_W:0]   text_len_r;
  logic [PADDR_W:0]   pat_len_r;
  logic               overlap_r;

  logic [TADDR_W+1:0] win_end;
  logic               win_fits;
  logic               char_eq;
  logic               last_char;
  logic [TADDR_W:0]   step;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  // Window check uses one extra bit so b + pat_len can never wrap past text_len.
  assign win_end   = {1'b0, b} + {{(TADDR_W+1-PADDR_W){1'b0}}, pat_len_r};
  assign win_fits  = (pat_len_r != '0) && (win_end <= {1'b0, text_len_r});
  assign char_eq   = (txt_data == pat_data);
  assign last_char = ((j + J_ONE) == pat_len_r);
  assign step      = overlap_r ? B_ONE : {{(TADDR_W-PADDR_W){1'b0}}, pat_len_r};

  assign txt_addr  = b[TADDR_W-1:0] + {{(TADDR_W-PADDR_W-1){1'b0}}, j};
  assign pat_addr  = j[PADDR_W-1:0];
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  always_comb begin
    state_nxt = state;
    match     = 1'b0;
    case (state)
      IDLE:    if (start) state_nxt = CHECK;
      CHECK:   state_nxt = win_fits ? FETCH : DONE;
      FETCH:   state_nxt = COMPARE;
      COMPARE: begin
        state_nxt = (char_eq && !last_char) ? FETCH : CHECK;
        match     = char_eq && last_char;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      b         <= '0;
      j         <= '0;
      count     <= '0;
      count_sat <= 1'b0;
      last_addr <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (start) begin
          b         <= {1'b0, start_addr};
          j         <= '0;
          count     <= '0;
          count_sat <= 1'b0;
          last_addr <= '0;
        end
        COMPARE: begin
          if (!char_eq) begin
            b <= b + B_ONE;
            j <= '0;
          end else if (!last_char) begin
            j <= j + J_ONE;
          end else begin
            last_addr <= b[TADDR_W-1:0];
            count     <= sat_inc(count);
            if (&count) count_sat <= 1'b1;
            j <= '0;
            b <= b + step;
          end
        end
        default: ;
      endcase
    end
  end

  // Search configuration is captured once per accepted start; contents are don't-care while idle.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      text_len_r <= text_len;
      pat_len_r  <= pat_len;
      overlap_r  <= overlap;
    end
  end

endmodule

// File: tb/tb_string_match_engine.sv
// Scoreboard bench for string_match_engine: directed searches push expected results,
// per-DUT monitors pop and compare on every done pulse.
module tb_string_match_engine;

  logic       clk = 1'b0;
  logic       rst;
  logic       start0, start1;
  logic [7:0] start_addr;
  logic [8:0] text_len;
  logic [3:0] pat_len;
  logic       overlap;

  logic [7:0] txt_addr0, txt_data0, pat_data0, count0, last_addr0;
  logic [2:0] pat_addr0;
  logic       busy0, done0, match0, count_sat0;

  logic [7:0] txt_addr1, txt_data1, pat_data1, last_addr1;
  logic [2:0] pat_addr1;
  logic [1:0] count1;
  logic       busy1, done1, match1, count_sat1;

  logic [7:0] text_mem [0:255];
  logic [7:0] pat_mem  [0:7];

  typedef struct {int cnt; int sat; int last; int nm; int lat;} exp_t;
  exp_t q0[$], q1[$];

  int checks = 0, errors = 0;
  int cyc0 = 0, nm0 = 0, dones0 = 0;
  int cyc1 = 0, nm1 = 0, dones1 = 0;

  always #5 clk = ~clk;

  string_match_engine dut (
    .clk(clk), .rst(rst), .start(start0), .start_addr(start_addr), .text_len(text_len),
    .pat_len(pat_len), .overlap(overlap), .txt_addr(txt_addr0), .txt_data(txt_data0),
    .pat_addr(pat_addr0), .pat_data(pat_data0), .busy(busy0), .done(done0), .match(match0),
    .count(count0), .count_sat(count_sat0), .last_addr(last_addr0)
  );

  string_match_engine #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .start(start1), .start_addr(start_addr), .text_len(text_len),
    .pat_len(pat_len), .overlap(overlap), .txt_addr(txt_addr1), .txt_data(txt_data1),
    .pat_addr(pat_addr1), .pat_data(pat_data1), .busy(busy1), .done(done1), .match(match1),
    .count(count1), .count_sat(count_sat1), .last_addr(last_addr1)
  );

  // Synchronous ROMs, one read port per DUT
  always @(posedge clk) begin
    txt_data0 <= text_mem[txt_addr0];
    pat_data0 <= pat_mem[pat_addr0];
    txt_data1 <= text_mem[txt_addr1];
    pat_data1 <= pat_mem[pat_addr1];
  end

  task automatic cmp(input string n, input int act, input int exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", n, act, exp_v);
    end
  endtask

  task automatic load(input string t, input string p);
    for (int i = 0; i < 256; i++) text_mem[i] = (i < t.len()) ? t[i] : 8'h2E;
    for (int i = 0; i < 8; i++)   pat_mem[i]  = (i < p.len()) ? p[i] : 8'h3F;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      cyc0 = 0; nm0 = 0;
    end else if (start0 && !busy0) begin
      cyc0 = 0; nm0 = 0;
    end else begin
      cyc0++;
      if (match0) nm0++;
      if (done0) begin
        dones0++;
        if (q0.size() == 0) begin
          checks++; errors++;
          $display("FAIL dut0_unexpected_done: got done pulse at cycle %0d, expected none", cyc0);
        end else begin
          e = q0.pop_front();
          cmp("dut0_count", int'(count0), e.cnt);
          cmp("dut0_count_sat", int'(count_sat0), e.sat);
          cmp("dut0_last_addr", int'(last_addr0), e.last);
          cmp("dut0_match_pulses", nm0, e.nm);
          if (e.lat >= 0) cmp("dut0_done_latency", cyc0, e.lat);
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      cyc1 = 0; nm1 = 0;
    end else if (start1 && !busy1) begin
      cyc1 = 0; nm1 = 0;
    end else begin
      cyc1++;
      if (match1) nm1++;
      if (done1) begin
        dones1++;
        if (q1.size() == 0) begin
          checks++; errors++;
          $display("FAIL dut1_unexpected_done: got done pulse at cycle %0d, expected none", cyc1);
        end else begin
          e = q1.pop_front();
          cmp("dut1_count", int'(count1), e.cnt);
          cmp("dut1_count_sat", int'(count_sat1), e.sat);
          cmp("dut1_last_addr", int'(last_addr1), e.last);
          cmp("dut1_match_pulses", nm1, e.nm);
          if (e.lat >= 0) cmp("dut1_done_latency", cyc1, e.lat);
        end
      end
    end
  end

  task automatic run(input int id, input int sa, input int tl, input int pl, input int ov,
                     input int ec, input int es, input int el, input int enm, input int elat,
                     input bit hold);
    exp_t e;
    int d, k;
    e = '{ec, es, el, enm, elat};
    @(posedge clk); #1;
    start_addr = 8'(sa); text_len = 9'(tl); pat_len = 4'(pl); overlap = ov[0];
    if (id == 0) begin q0.push_back(e); d = dones0; start0 = 1'b1; end
    else         begin q1.push_back(e); d = dones1; start1 = 1'b1; end
    @(posedge clk); #1;
    if (!hold) begin
      start0 = 1'b0; start1 = 1'b0;
    end else begin
      start_addr = 8'd3; text_len = 9'd2; pat_len = 4'd1; overlap = 1'b0;
    end
    k = 0;
    while (((id == 0) ? dones0 : dones1) == d && k < 2000) begin
      @(posedge clk); #1;
      k++;
      if (hold && done0) start0 = 1'b0;
    end
    start0 = 1'b0; start1 = 1'b0;
    cmp("run_done_count", ((id == 0) ? dones0 : dones1) - d, 1);
    repeat (3) @(posedge clk);
    #1;
    cmp("count_hold_after_done", (id == 0) ? int'(count0) : int'(count1), ec);
  endtask

  initial begin
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0;
    start_addr = '0; text_len = '0; pat_len = '0; overlap = 1'b0;
    load("ABABAB", "ABA");
    repeat (3) @(posedge clk);
    #1;
    cmp("rst_busy", int'(busy0), 0);
    cmp("rst_done", int'(done0), 0);
    cmp("rst_count", int'(count0), 0);
    cmp("rst_last_addr", int'(last_addr0), 0);
    cmp("rst_txt_addr", int'(txt_addr0), 0);
    cmp("rst_count_sat1", int'(count_sat1), 0);
    rst = 1'b0;

    // ABA in ABABAB, overlapping and not, and from offset 1
    run(0, 0, 6, 3, 1, 2, 0, 2, 2, 22, 1'b0);
    run(0, 0, 6, 3, 0, 1, 0, 0, 1, 12, 1'b0);
    run(0, 1, 6, 3, 1, 1, 0, 2, 1, 15, 1'b0);
    load("ABABAB", "BAB");
    run(0, 0, 6, 3, 0, 1, 0, 1, 1, 12, 1'b0);

    // Degenerate windows terminate straight from the first CHECK
    run(0, 0, 6, 0, 1, 0, 0, 0, 0, 2, 1'b0);
    run(0, 0, 3, 4, 1, 0, 0, 0, 0, 2, 1'b0);

    // Two-bit counter saturates at 3
    load("AAAAAA", "A");
    run(1, 0, 6, 1, 1, 3, 1, 5, 6, 20, 1'b0);

    // start held high and inputs scrambled during the search
    load("ABABAB", "ABA");
    run(0, 0, 6, 3, 1, 2, 0, 2, 2, 22, 1'b1);

    // Reset in the COMPARE of window 1, after the first match has been counted
    @(posedge clk); #1;
    start_addr = 8'd0; text_len = 9'd6; pat_len = 4'd3; overlap = 1'b1; start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    cmp("mid_count", int'(count0), 1);
    cmp("mid_txt_addr", int'(txt_addr0), 1);
    cmp("mid_busy", int'(busy0), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    cmp("abort_busy", int'(busy0), 0);
    cmp("abort_done", int'(done0), 0);
    cmp("abort_match", int'(match0), 0);
    cmp("abort_count", int'(count0), 0);
    cmp("abort_count_sat", int'(count_sat0), 0);
    cmp("abort_last_addr", int'(last_addr0), 0);
    cmp("abort_txt_addr", int'(txt_addr0), 0);
    cmp("abort_pat_addr", int'(pat_addr0), 0);
    rst = 1'b0;
    run(0, 0, 6, 3, 1, 2, 0, 2, 2, 22, 1'b0);

    repeat (5) @(posedge clk);
    cmp("dut0_pending_results", q0.size(), 0);
    cmp("dut1_pending_results", q1.size(), 0);
    cmp("dut0_total_dones", dones0, 8);
    cmp("dut1_total_dones", dones1, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
